// File: rtl/ro2_axil_responder.sv
// AXI4-Lite register front-end of the RO2 ring-oscillator sensor: four R/W registers,
// STATUS/COUNT read-only registers, and a windowed tick counter driven by CTRL.start.
module ro2_axil_responder #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   input  logic                              ro_tick,
   output logic                              meas_done
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t      r_state, w_state_next;
   logic [31:0] r_regs [4];
   logic [31:0] r_timer, w_timer_next;
   logic [31:0] r_count, w_count_next;

   logic        r_ready_en;
   logic        r_aw_full, r_w_full, r_bvalid, r_rvalid;
   logic [2:0]  r_aw_addr;
   logic [31:0] r_w_data, r_rdata, w_rd_mux;
   logic [3:0]  r_w_strb;

   logic w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_start, w_busy, w_done;
   logic w_unused;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // READY outputs stay low until the first clock after reset release.
   assign S_AXI_AWREADY = r_ready_en && !r_aw_full && !r_bvalid;
   assign S_AXI_WREADY  = r_ready_en && !r_w_full && !r_bvalid;
   assign S_AXI_ARREADY = r_ready_en && !r_rvalid;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = 2'b00;

   assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_w_hs   = S_AXI_WVALID && S_AXI_WREADY;
   assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign w_commit = r_aw_full && r_w_full && !r_bvalid;
   assign w_start  = w_commit && (r_aw_addr == 3'd0) && r_w_strb[0] && r_w_data[0];

   assign w_busy    = (r_state == ST_RUN);
   assign w_done    = (r_state == ST_DONE);
   assign meas_done = w_done;

   always_comb begin
      w_rd_mux = 32'd0;
      case (S_AXI_ARADDR[4:2])
         3'd0:    w_rd_mux = r_regs[0];
         3'd1:    w_rd_mux = r_regs[1];
         3'd2:    w_rd_mux = r_regs[2];
         3'd3:    w_rd_mux = r_regs[3];
         3'd4:    w_rd_mux = {30'd0, w_done, w_busy};
         3'd5:    w_rd_mux = r_count;
         default: w_rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_ready_en <= 1'b0;
         r_aw_full  <= 1'b0;
         r_w_full   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_rvalid   <= 1'b0;
         r_aw_addr  <= 3'd0;
         r_w_data   <= 32'd0;
         r_w_strb   <= 4'd0;
         r_rdata    <= 32'd0;
         for (int i = 0; i < 4; i++) r_regs[i] <= 32'd0;
      end else begin
         r_ready_en <= 1'b1;
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_addr <= S_AXI_AWADDR[4:2];
         end
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_w_data <= S_AXI_WDATA;
            r_w_strb <= S_AXI_WSTRB;
         end
         // Holders stay full while BVALID is up, so commit fires exactly once per write.
         if (w_commit) begin
            r_bvalid <= 1'b1;
            if (!r_aw_addr[2]) begin
               for (int b = 0; b < 4; b++)
                  if (r_w_strb[b]) r_regs[r_aw_addr[1:0]][8*b +: 8] <= r_w_data[8*b +: 8];
            end
         end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
         end
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
         end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state <= ST_IDLE;
         r_timer <= 32'd0;
         r_count <= 32'd0;
      end else begin
         r_state <= w_state_next;
         r_timer <= w_timer_next;
         r_count <= w_count_next;
      end
   end

   // RUN spans timer = WINDOW down to 0 inclusive, i.e. WINDOW+1 sampled cycles.
   always_comb begin
      w_state_next = r_state;
      w_timer_next = r_timer;
      w_count_next = r_count;
      case (r_state)
         ST_RUN: begin
            if (ro_tick && (r_count != 32'hFFFF_FFFF)) w_count_next = r_count + 32'd1;
            if (r_timer == 32'd0) w_state_next = ST_DONE;
            else                  w_timer_next = r_timer - 32'd1;
         end
         default: ;
      endcase
      if (w_start) begin
         w_state_next = ST_RUN;
         w_timer_next = r_regs[1];
         w_count_next = 32'd0;
      end
   end

endmodule

// File: tb/tb_ro2_axil_responder.sv
// Self-checking bench for ro2_axil_responder: table-driven register accesses plus
// hand-written channel-ordering, measurement, restart and reset sequences.
module tb_ro2_axil_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        ro_tick, meas_done;
   int          tick_mode;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   ro2_axil_responder dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .ro_tick(ro_tick), .meas_done(meas_done)
   );

   // ro_tick generator: 0 = off, 1 = every second cycle, 2 = constant high
   initial begin
      ro_tick = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (tick_mode)
            1:       ro_tick = ~ro_tick;
            2:       ro_tick = 1'b1;
            default: ro_tick = 1'b0;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic recv_b(input string name);
      int n = 0;
      bready = 1'b1;
      while (!bvalid && n < 50) begin tick(1); n++; end
      check({name, "_bvalid"}, {31'd0, bvalid}, 32'd1);
      check({name, "_bresp"}, {30'd0, bresp}, 32'd0);
      tick(1);
      bready = 1'b0;
   endtask

   task automatic send_aw(input logic [4:0] a);
      int n = 0;
      awaddr = a; awvalid = 1'b1;
      while (!awready && n < 50) begin tick(1); n++; end
      if (n >= 50) check("aw_timeout", 32'd1, 32'd0);
      tick(1);
      awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      wdata = d; wstrb = s; wvalid = 1'b1;
      while (!wready && n < 50) begin tick(1); n++; end
      if (n >= 50) check("w_timeout", 32'd1, 32'd0);
      tick(1);
      wvalid = 1'b0;
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      int  n = 0;
      bit  aw_hs, w_hs;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      while ((awvalid || wvalid) && n < 50) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick(1);
         if (aw_hs) awvalid = 1'b0;
         if (w_hs)  wvalid  = 1'b0;
         n++;
      end
      if (n >= 50) begin
         check("aw_w_timeout", 32'd1, 32'd0);
         awvalid = 1'b0; wvalid = 1'b0;
      end
      recv_b($sformatf("wr_%02h", a));
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
      int n = 0;
      araddr = a; arvalid = 1'b1;
      while (!arready && n < 50) begin tick(1); n++; end
      if (n >= 50) check("ar_timeout", 32'd1, 32'd0);
      tick(1);
      arvalid = 1'b0;
      rready = 1'b1;
      n = 0;
      while (!rvalid && n < 50) begin tick(1); n++; end
      if (n >= 50) check("r_timeout", 32'd1, 32'd0);
      d = rdata;
      check($sformatf("rresp_%02h", a), {30'd0, rresp}, 32'd0);
      tick(1);
      rready = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(a, d);
      check(name, d, exp);
   endtask

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[18];

   initial begin
      rst_n = 1'b0; tick_mode = 0;
      awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
      araddr = '0; arprot = '0; arvalid = 0; rready = 0;

      vecs[0]  = '{1'b1, 5'h00, 32'd1,         4'hF, 32'd0};
      vecs[1]  = '{1'b1, 5'h04, 32'd2,         4'hF, 32'd0};
      vecs[2]  = '{1'b1, 5'h08, 32'd3,         4'hF, 32'd0};
      vecs[3]  = '{1'b1, 5'h0C, 32'd4,         4'hF, 32'd0};
      vecs[4]  = '{1'b0, 5'h00, 32'd0,         4'h0, 32'd1};
      vecs[5]  = '{1'b0, 5'h04, 32'd0,         4'h0, 32'd2};
      vecs[6]  = '{1'b0, 5'h08, 32'd0,         4'h0, 32'd3};
      vecs[7]  = '{1'b0, 5'h0C, 32'd0,         4'h0, 32'd4};
      vecs[8]  = '{1'b1, 5'h10, 32'h0000_FFFF, 4'hF, 32'd0};
      vecs[9]  = '{1'b0, 5'h10, 32'd0,         4'h0, 32'h2};
      vecs[10] = '{1'b0, 5'h14, 32'd0,         4'h0, 32'h0};
      vecs[11] = '{1'b1, 5'h1C, 32'd5,         4'hF, 32'd0};
      vecs[12] = '{1'b0, 5'h1C, 32'd0,         4'h0, 32'h0};
      vecs[13] = '{1'b0, 5'h18, 32'd0,         4'h0, 32'h0};
      vecs[14] = '{1'b1, 5'h0C, 32'hDEAD_BEEF, 4'h8, 32'd0};
      vecs[15] = '{1'b0, 5'h0C, 32'd0,         4'h0, 32'hDE00_0004};
      vecs[16] = '{1'b1, 5'h0C, 32'h1234_5678, 4'h3, 32'd0};
      vecs[17] = '{1'b0, 5'h0C, 32'd0,         4'h0, 32'hDE00_5678};

      // reset state
      tick(3);
      check("rst_awready", {31'd0, awready}, 32'd0);
      check("rst_wready", {31'd0, wready}, 32'd0);
      check("rst_arready", {31'd0, arready}, 32'd0);
      check("rst_bvalid", {31'd0, bvalid}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_meas_done", {31'd0, meas_done}, 32'd0);
      rst_n = 1'b1;
      tick(2);

      // register map vectors (CTRL=1 with WINDOW=0 runs one idle-tick cycle -> done)
      foreach (vecs[i]) begin
         if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
         else read_check($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
      end

      // read and write to the same register committing on the same edge
      axi_write(5'h08, 32'h11, 4'hF);
      awaddr = 5'h08; wdata = 32'h22; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      tick(1);
      awvalid = 0; wvalid = 0;
      araddr = 5'h08; arvalid = 1;
      tick(1);
      arvalid = 0;
      check("same_cycle_bvalid", {31'd0, bvalid}, 32'd1);
      check("same_cycle_rvalid", {31'd0, rvalid}, 32'd1);
      check("same_cycle_old_value", rdata, 32'h11);
      rready = 1; tick(1); rready = 0;
      recv_b("same_cycle");
      read_check("same_cycle_new_value", 5'h08, 32'h22);

      // AW three cycles before W, then B held off five cycles
      axi_write(5'h08, 32'h0, 4'hF);
      send_aw(5'h08);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check($sformatf("aw_first_no_b_%0d", i), {31'd0, bvalid}, 32'd0);
      end
      send_w(32'hA5A5_A5A5, 4'b0101);
      tick(1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("b_stall_bvalid_%0d", i), {31'd0, bvalid}, 32'd1);
         check($sformatf("b_stall_awready_%0d", i), {31'd0, awready}, 32'd0);
         tick(1);
      end
      recv_b("aw_first");
      read_check("aw_first_data", 5'h08, 32'h00A5_00A5);

      // W three cycles before AW
      axi_write(5'h08, 32'h0, 4'hF);
      send_w(32'hA5A5_A5A5, 4'b0101);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check($sformatf("w_first_no_b_%0d", i), {31'd0, bvalid}, 32'd0);
      end
      send_aw(5'h08);
      recv_b("w_first");
      read_check("w_first_data", 5'h08, 32'h00A5_00A5);

      // window 9, tick every second cycle -> 10 sampled cycles -> 5
      axi_write(5'h04, 32'd9, 4'hF);
      tick_mode = 1;
      axi_write(5'h00, 32'd1, 4'hF);
      read_check("w9_status_busy", 5'h10, 32'h1);
      tick(20);
      read_check("w9_status_done", 5'h10, 32'h2);
      read_check("w9_count", 5'h14, 32'd5);
      check("w9_meas_done", {31'd0, meas_done}, 32'd1);

      // window 0, tick constant high -> 1
      tick_mode = 2;
      axi_write(5'h04, 32'd0, 4'hF);
      axi_write(5'h00, 32'd1, 4'hF);
      tick(5);
      read_check("w0_count", 5'h14, 32'd1);
      read_check("w0_status", 5'h10, 32'h2);
      axi_write(5'h10, 32'hFFFF, 4'hF);
      read_check("w0_status_ro", 5'h10, 32'h2);
      read_check("w0_unmapped", 5'h18, 32'h0);

      // restart mid-run: second run must extend past the end of the first
      axi_write(5'h04, 32'd100, 4'hF);
      axi_write(5'h00, 32'd1, 4'hF);
      tick(17);
      axi_write(5'h00, 32'd1, 4'hF);
      tick(85);
      read_check("restart_still_busy", 5'h10, 32'h1);
      check("restart_meas_done_low", {31'd0, meas_done}, 32'd0);
      tick(30);
      read_check("restart_count", 5'h14, 32'd101);
      read_check("restart_status", 5'h10, 32'h2);

      // asynchronous reset with RVALID pending and the counter running
      axi_write(5'h00, 32'd1, 4'hF);
      araddr = 5'h14; arvalid = 1;
      tick(1);
      arvalid = 0;
      check("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("async_rst_rdata", rdata, 32'd0);
      check("async_rst_arready", {31'd0, arready}, 32'd0);
      check("async_rst_meas_done", {31'd0, meas_done}, 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("post_rst_no_r", {31'd0, rvalid}, 32'd0);
      check("post_rst_no_b", {31'd0, bvalid}, 32'd0);
      tick_mode = 0;
      for (int i = 0; i < 6; i++)
         read_check($sformatf("post_rst_reg%0d", i), 5'(i * 4), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
